// File: rtl/mul_div_unit_if.sv
// Multiply/divide unit bus.
//   master : start, op, A, B, hi_we, lo_we, wdata  -> unit
//   slave  : busy, done, HI, LO                     -> master
interface mul_div_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output start, op, A, B, hi_we, lo_we, wdata,
      input  busy, done, HI, LO
   );

   modport slave (
      input  start, op, A, B, hi_we, lo_we, wdata,
      output busy, done, HI, LO
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit (MULTU, MULT, DIVU, DIV) writing the HI/LO
// pair, with MTHI/MTLO writes and continuous HI/LO read-out.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of mul_div_unit_if
//              start/op/A/B launch an operation (op 00=MULTU 01=MULT 10=DIVU 11=DIV)
//              hi_we/lo_we/wdata implement MTHI/MTLO
//              busy, done (one-cycle pulse), HI, LO are registered outputs
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           reset_n,
   mul_div_unit_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nx;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   opnd_q;     // multiplicand (mul) or divisor (div)
   logic [WIDTH-1:0]   work_hi;    // accumulator high half / partial remainder
   logic [WIDTH-1:0]   work_lo;    // multiplier being shifted out / dividend -> quotient
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [CNT_W-1:0]   cnt;
   logic               neg_res, neg_rem, done_q;

   logic               load, last;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
   logic [WIDTH-1:0]   nx_hi, nx_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Next-state and control strobes.
   always_comb begin
      state_nx = state;
      load     = '0;
      last     = '0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = RUN;
               load     = '1;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nx = IDLE;
               last     = '1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // One iteration step plus final sign correction.
   always_comb begin
      a_abs = (bus.op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      b_abs = (bus.op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;

      // Shift-add: the carry out of the add becomes the new accumulator MSB,
      // the sum LSB drops into the vacated top of the multiplier register.
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : '0);
      // Restoring divide: the borrow bit of the trial subtract selects the quotient bit.
      rem_shift = {work_hi, work_lo[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opnd_q};

      if (op_q[1]) begin
         if (!rem_diff[WIDTH]) begin
            nx_hi = rem_diff[WIDTH-1:0];
            nx_lo = {work_lo[WIDTH-2:0], 1'b1};
         end else begin
            nx_hi = rem_shift[WIDTH-1:0];
            nx_lo = {work_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         nx_hi = mul_sum[WIDTH:1];
         nx_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
      end

      prod_fix = neg_res ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
      quo_fix  = neg_res ? -nx_lo : nx_lo;
      rem_fix  = neg_rem ? -nx_hi : nx_hi;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= '0;
         opnd_q  <= '0;
         work_hi <= '0;
         work_lo <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt     <= '0;
         neg_res <= '0;
         neg_rem <= '0;
         done_q  <= '0;
      end else begin
         done_q <= last;
         if (load) begin
            op_q    <= bus.op;
            opnd_q  <= bus.op[1] ? b_abs : a_abs;
            work_lo <= bus.op[1] ? a_abs : b_abs;
            work_hi <= '0;
            cnt     <= '0;
            neg_res <= bus.op[0] & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_rem <= bus.op[0] & bus.A[WIDTH-1];
         end else if (state == RUN) begin
            work_hi <= nx_hi;
            work_lo <= nx_lo;
            cnt     <= cnt + 1'b1;
            if (last) begin
               if (op_q[1]) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
            end
         end else begin
            // IDLE without start: MTHI/MTLO.
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, randomized
// operations against an arithmetic reference model, latency, start/MTHI/MTLO
// interaction and mid-operation reset.
module tb_mul_div_unit;

   logic clk;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] cur_hi, cur_lo;   // values HI/LO must present when not updating

   mul_div_unit_if #(.WIDTH(32)) bus ();

   mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference results from plain integer arithmetic.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      logic [63:0] p;
      longint      sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: p = {32'b0, a} * {32'b0, b};
         2'b01: p = sa * sb;
         default: p = '0;
      endcase
      hi = p[63:32];
      lo = p[31:0];
      if (op == 2'b10) begin
         if (b == 0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
         end else begin
            lo = a / b;
            hi = a % b;
         end
      end else if (op == 2'b11) begin
         if (b == 0) begin
            q = 64'h0000_0000_FFFF_FFFF;
            r = (sa < 0) ? -sa : sa;
            if (sa < 0) begin
               q = -q;
               r = -r;
            end
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Waits (bounded) for done; checks busy/hold during the run, the done
   // cycle number and the result. Returns in the done cycle.
   task automatic wait_done(input string tag, input int start_cyc, input int exp_cyc,
                            input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int          cyc;
      logic        run_ok;
      logic [31:0] eh, el;
      model(op, a, b, eh, el);
      cyc    = start_cyc;
      run_ok = 1'b1;
      while (bus.done !== 1'b1 && cyc < start_cyc + 80) begin
         if (bus.busy !== 1'b1 || bus.HI !== cur_hi || bus.LO !== cur_lo) run_ok = 1'b0;
         tick();
         cyc++;
      end
      check({tag, " busy/hold"}, 64'(run_ok), 64'd1);
      check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
      check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
      check({tag, " HI"}, 64'(bus.HI), 64'(eh));
      check({tag, " LO"}, 64'(bus.LO), 64'(el));
      cur_hi = eh;
      cur_lo = el;
   endtask

   task automatic after_done(input string tag);
      tick();
      check({tag, " done drop"}, 64'(bus.done), 64'd0);
      check({tag, " HI hold"}, 64'(bus.HI), 64'(cur_hi));
   endtask

   task automatic full_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      launch(op, a, b);
      wait_done(tag, 1, 33, op, a, b);
      after_done(tag);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      logic        saw_done;

      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.A     = '0;
      bus.B     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      cur_hi    = '0;
      cur_lo    = '0;
      tick();
      tick();
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset HI", 64'(bus.HI), 64'd0);
      check("reset LO", 64'(bus.LO), 64'd0);
      reset_n = 1'b1;
      tick();

      // Directed corners.
      full_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu max HI const", 64'(cur_hi), 64'h0000_0000_FFFF_FFFE);
      full_op("mult -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7);
      full_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2);
      full_op("divu /0", 2'b10, 32'd100, 32'd0);
      full_op("div ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      full_op("div neg/0", 2'b11, 32'hFFFF_FFFB, 32'd0);
      full_op("mult minmin", 2'b01, 32'h8000_0000, 32'h8000_0000);

      // Randomized operations.
      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case (i % 6)
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         full_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
      end

      // Start while busy is ignored; start in the done cycle is accepted.
      launch(2'b00, 32'd1000, 32'd3000);
      repeat (4) tick();
      bus.op    = 2'b11;
      bus.A     = 32'h1234_5678;
      bus.B     = 32'd9;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done("ignored start", 6, 33, 2'b00, 32'd1000, 32'd3000);
      launch(2'b01, 32'hFFFF_FF00, 32'd77);
      wait_done("back2back", 34, 66, 2'b01, 32'hFFFF_FF00, 32'd77);
      after_done("back2back");

      // MTHI/MTLO.
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      tick();
      bus.hi_we = 1'b0;
      check("mthi HI", 64'(bus.HI), 64'h1234);
      check("mthi LO kept", 64'(bus.LO), 64'(cur_lo));
      cur_hi = 32'h0000_1234;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h5A5A_A5A5;
      tick();
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      check("mthi+mtlo HI", 64'(bus.HI), 64'h5A5A_A5A5);
      check("mthi+mtlo LO", 64'(bus.LO), 64'h5A5A_A5A5);
      cur_hi = 32'h5A5A_A5A5;
      cur_lo = 32'h5A5A_A5A5;

      launch(2'b10, 32'd1000, 32'd7);
      tick();
      tick();
      bus.lo_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      tick();
      bus.lo_we = 1'b0;
      check("mtlo busy dropped", 64'(bus.LO), 64'(cur_lo));
      wait_done("mtlo busy op", 4, 33, 2'b10, 32'd1000, 32'd7);
      after_done("mtlo busy op");

      bus.lo_we = 1'b1;
      bus.wdata = 32'hBEEF_0000;
      launch(2'b01, 32'd6, 32'hFFFF_FFF9);
      bus.lo_we = 1'b0;
      check("mtlo+start dropped", 64'(bus.LO), 64'(cur_lo));
      wait_done("start wins", 1, 33, 2'b01, 32'd6, 32'hFFFF_FFF9);
      after_done("start wins");

      // Reset mid-operation: immediate clear, no done afterwards.
      launch(2'b00, 32'd5, 32'd7);
      repeat (9) tick();
      reset_n = 1'b0;
      #1;
      check("midreset busy", 64'(bus.busy), 64'd0);
      check("midreset HI", 64'(bus.HI), 64'd0);
      check("midreset LO", 64'(bus.LO), 64'd0);
      #2;
      reset_n  = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      check("midreset no done", 64'(saw_done), 64'd0);
      check("midreset LO after", 64'(bus.LO), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage, beside the combinational bitwise logic slices (and/or/nor/xor) and the adder.
- Implements MULT, MULTU, DIV and DIVU into the architectural HI/LO pair.
- Supports MTHI/MTLO writes and continuous HI/LO read-out for MFHI/MFLO.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- HI  output  WIDTH  high product / remainder
- LO  output  WIDTH  low product / quotient

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, HI=0, LO=0; counter and internal operand regs cleared.
  - Asserting reset mid-operation aborts the operation immediately. No done pulse; HI/LO read 0.
- States:
  - IDLE: if start, go to RUN.
  - RUN: iterate; leave to IDLE after WIDTH iterations.
- Load edge (IDLE with start=1):
  - Capture op.
  - Capture |A| and |B| for signed ops, raw values for unsigned.
  - Record result sign and remainder sign (sign of A for DIV).
  - counter=0; busy=1 after this edge.
- RUN, one iteration per edge, counter increments:
  - Multiply: shift-add, one multiplier bit per edge, LSB first, into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge, MSB first.
- Final RUN edge (counter=WIDTH-1):
  - Write HI/LO with sign correction applied:
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; negate the remainder if A<0.
  - done=1 and busy=0 after this edge; done drops after one cycle.
- Latency: start high in cycle 0 → load edge 1 → iteration edges 2..WIDTH+1 → result visible and done=1 in cycle WIDTH+1 (33 for WIDTH=32).
- A back-to-back start in the done cycle is accepted; state is IDLE then.
- start while busy=1: ignored; no queueing.
- Divide by zero, no trap, still WIDTH iterations:
  - DIVU: LO=all ones, HI=A.
  - DIV: raw unsigned result of |A|/0, then sign correction as above.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO:
  - In IDLE without start, hi_we/lo_we write wdata at the next edge.
  - Both may be written in the same cycle; both get wdata.
  - Writes while busy=1 are dropped.
  - Writes in the same cycle as an accepted start are dropped; start wins.
- HI/LO hold their value during RUN; intermediate results are never exposed.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-op: start MULTU A=5, B=7, assert reset_n=0 at cycle 10 → busy=0, HI=0, LO=0 immediately; no done pulse ever follows.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → done in cycle 33 (exactly one cycle); HI=0xFFFFFFFE, LO=0x00000001; busy high in cycles 1-32.
- MULT A=-3 (0xFFFFFFFD), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 → LO=0xFFFFFFFF, HI=100. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Pulse start again at cycle 5 with different operands → ignored; first result unchanged at cycle 33. Start in the done cycle → second result at cycle 66.
- MTHI/MTLO ordering:
  - hi_we=1, wdata=0x1234 in IDLE → HI=0x1234 next cycle.
  - lo_we during busy → LO unchanged.
  - lo_we together with start → write dropped; LO = operation result.
